sdram_sched: RTL and testbench
==============================

SDRAM_SCHED -- requirements
Module: sdram_sched

Interface
REQ-001 clk_sys  in  1  system clock; all logic on its rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 load_en  in  1  ROM download active; high = write mode, low = read mode.
REQ-004 wr_req  in  1  one-cycle write strobe from the loader (tiles/sprites/theme strobes ORed).
REQ-005 wr_addr  in  25  SDRAM word address of the write.
REQ-006 wr_data  in  16  write data.
REQ-007 ioctl_wait  out  1  backpressure to the download source.
REQ-008 wr_ovf  out  1  sticky overflow flag.
REQ-009 rd0_req / rd1_req  in  1 each  level read requests (0 = tiles, 1 = sprites).
REQ-010 rd0_addr / rd1_addr  in  25 each  read word addresses.
REQ-011 rd0_data / rd1_data  out  32 each  read data.
REQ-012 rd0_valid / rd1_valid  out  1 each  one-cycle read-complete pulses.
REQ-013 sdram_req  out  1; sdram_we  out  1; sdram_addr  out  25; sdram_din  out  16  SDRAM port command outputs.
REQ-014 sdram_ack  in  1  command accepted; sdram_rdy  in  1  read data valid; sdram_dout  in  32  read data.

Function
REQ-015 Write FIFO SHALL be 4 entries of {addr, data}; wr_req pushes at the same rising edge it is sampled.
REQ-016 Push and pop on the same edge SHALL leave the count unchanged.
REQ-017 Push while full SHALL be dropped and set wr_ovf, which stays high until reset.
REQ-018 ioctl_wait SHALL be high while count >= 3, registered, so it updates the cycle after the count changes.
REQ-019 FSM states: IDLE, WR_ISSUE, RD_ISSUE, RD_WAIT.
REQ-020 IDLE -> WR_ISSUE when the FIFO is non-empty; write mode has absolute priority over reads.
REQ-021 IDLE -> RD_ISSUE only when load_en is low, the FIFO is empty and a read request is pending.
REQ-022 Read arbitration SHALL be round-robin: when both requests are high, grant the requester not served last; after reset, rd0 is treated as last served, so rd1 gets the first tie.
REQ-023 WR_ISSUE SHALL drive sdram_req=1, sdram_we=1, and sdram_addr/sdram_din from the FIFO head, holding them until sdram_ack is sampled high.
REQ-024 On that ack edge the FIFO SHALL pop, sdram_req SHALL drop, and the FSM SHALL return to IDLE.
REQ-025 RD_ISSUE SHALL drive sdram_req=1, sdram_we=0, and the granted address, held until ack; the FSM then moves to RD_WAIT.
REQ-026 In RD_WAIT, sdram_rdy SHALL capture sdram_dout into the granted rdN_data, pulse rdN_valid for exactly one cycle on the next cycle, and return the FSM to IDLE.
REQ-027 Requesters hold rdN_req until rdN_valid; a request dropped mid-transaction still completes.
REQ-028 A load_en rise during RD_ISSUE/RD_WAIT SHALL NOT abort the read; queued writes start after it completes.
REQ-029 Minimum write cost SHALL be 2 cycles per word (IDLE -> WR_ISSUE -> ack with 0 wait).
REQ-030 rdN_data SHALL keep its last value between reads.

Reset
REQ-031 reset SHALL force:
- FSM to IDLE and the FIFO empty
- sdram_req, sdram_we, ioctl_wait, wr_ovf and rdN_valid to 0
- sdram_addr, sdram_din and rdN_data to 0
- round-robin pointer to "rd0 last".
REQ-032 Reset mid-transaction SHALL abandon it without a completion pulse; sdram_req SHALL be low on the first cycle after reset.

Configuration
REQ-033 Macro SDRAM_SCHED_TIMEOUT_EN, when defined, SHALL add an 8-bit RD_WAIT counter with this behaviour:
- 255 cycles in RD_WAIT without sdram_rdy returns the FSM to IDLE
- rdN_valid pulses with rdN_data = 0
- sticky output rd_timeout (1 bit, reset 0) is set.
REQ-034 Without SDRAM_SCHED_TIMEOUT_EN, the rd_timeout port SHALL be absent and RD_WAIT SHALL wait indefinitely.

Verification
REQ-035 load_en=1; wr_req with addr 0x000010, data 0xA55A; ack 2 cycles after req -> one SDRAM write with those values; FIFO empty afterwards.
REQ-036 Five back-to-back wr_req, ack held low -> ioctl_wait high from the cycle after the 3rd push; 5th push dropped; wr_ovf=1.
REQ-037 load_en=0; rd0_req and rd1_req high together; sdram_rdy 3 cycles after ack with dout 0x11223344 then 0x55667788 -> rd1 served first (rd1_data=0x11223344), then rd0 (rd0_data=0x55667788); each valid pulses once.
REQ-038 FIFO holds 1 entry and rd0_req rises in the same cycle -> write issued before the read.
REQ-039 reset asserted in RD_WAIT -> no rd0_valid pulse; sdram_req=0 and all outputs 0 the next cycle.
REQ-040 Timeout build with sdram_rdy never asserted -> rd0_valid pulses with data 0 after 255 cycles in RD_WAIT; rd_timeout=1.

Source files
------------

// File: rtl/sdram_sched_if.sv
// sdram_sched_if -- command/response bundle between the scheduler and the
// SDRAM controller port.
//
// Handshake: the scheduler raises sdram_req with sdram_we/sdram_addr/sdram_din
// and holds them stable until it samples sdram_ack high on a rising edge; that
// edge completes the command. For reads, sdram_rdy is a one-cycle strobe
// qualifying sdram_dout, arriving any number of cycles after the ack.
//
// Signals:
//   sdram_req  scheduler -> controller  command request
//   sdram_we   scheduler -> controller  1 = write, 0 = read
//   sdram_addr scheduler -> controller  25-bit word address
//   sdram_din  scheduler -> controller  16-bit write data
//   sdram_ack  controller -> scheduler  command accepted
//   sdram_rdy  controller -> scheduler  read data valid
//   sdram_dout controller -> scheduler  32-bit read data
interface sdram_sched_if;
    logic        sdram_req;
    logic        sdram_we;
    logic [24:0] sdram_addr;
    logic [15:0] sdram_din;
    logic        sdram_ack;
    logic        sdram_rdy;
    logic [31:0] sdram_dout;

    modport master (
        output sdram_req, sdram_we, sdram_addr, sdram_din,
        input  sdram_ack, sdram_rdy, sdram_dout
    );

    modport slave (
        input  sdram_req, sdram_we, sdram_addr, sdram_din,
        output sdram_ack, sdram_rdy, sdram_dout
    );
endinterface

// File: rtl/sdram_sched.sv
// sdram_sched -- shares one SDRAM port between a ROM-download write stream
// (buffered in a 4-entry FIFO) and two round-robin read requesters.
//
// Optional feature macro: SDRAM_SCHED_TIMEOUT_EN adds a 255-cycle RD_WAIT
// timeout and the sticky rd_timeout output.
//
// Ports:
//   clk_sys, reset          clock, synchronous active-high reset
//   load_en                 download active (writes only, reads held off)
//   wr_req/wr_addr/wr_data  write strobe into the FIFO
//   ioctl_wait              registered backpressure, high while FIFO >= 3
//   wr_ovf                  sticky: a write arrived with the FIFO full
//   rdN_req/rdN_addr        level read requests, held until rdN_valid
//   rdN_data/rdN_valid      read result and one-cycle completion pulse
//   rd_timeout              (macro only) sticky read-timeout flag
//   dbg_state               current FSM state
//   sdram                   SDRAM command port (master side)
module sdram_sched (
    input  logic                 clk_sys,
    input  logic                 reset,
    input  logic                 load_en,
    input  logic                 wr_req,
    input  logic [24:0]          wr_addr,
    input  logic [15:0]          wr_data,
    output logic                 ioctl_wait,
    output logic                 wr_ovf,
    input  logic                 rd0_req,
    input  logic                 rd1_req,
    input  logic [24:0]          rd0_addr,
    input  logic [24:0]          rd1_addr,
    output logic [31:0]          rd0_data,
    output logic [31:0]          rd1_data,
    output logic                 rd0_valid,
    output logic                 rd1_valid,
`ifdef SDRAM_SCHED_TIMEOUT_EN
    output logic                 rd_timeout,
`endif
    output logic [1:0]           dbg_state,
    sdram_sched_if.master        sdram
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WR_ISSUE = 2'd1,
        S_RD_ISSUE = 2'd2,
        S_RD_WAIT  = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_req, r_we;
    logic [24:0] r_addr;
    logic [15:0] r_din;
    logic        r_gnt1;       // read in flight belongs to rd1
    logic        r_last_rd1;   // rd1 was served last (0 after reset)
    logic        r_rd0_valid, r_rd1_valid;
    logic [31:0] r_rd0_data, r_rd1_data;

    // write FIFO
    logic [24:0] r_fifo_addr [4];
    logic [15:0] r_fifo_data [4];
    logic [1:0]  r_wr_ptr, r_rd_ptr;
    logic [2:0]  r_count;
    logic        r_ioctl_wait, r_wr_ovf;

    logic        w_full, w_empty, w_push, w_pop, w_grant1;
    logic [2:0]  w_count_next;

    assign w_full   = (r_count == 3'd4);
    assign w_empty  = (r_count == 3'd0);
    // a write arriving while full is dropped even if a pop happens on the same edge
    assign w_push   = wr_req && !w_full;
    assign w_pop    = (r_state == S_WR_ISSUE) && sdram.sdram_ack;
    // round robin: on a tie, grant whichever side was not served last
    assign w_grant1 = rd1_req && (!rd0_req || !r_last_rd1);

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop)
            w_count_next = r_count + 3'd1;
        else if (w_pop && !w_push)
            w_count_next = r_count - 3'd1;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_wr_ptr     <= 2'd0;
            r_rd_ptr     <= 2'd0;
            r_count      <= 3'd0;
            r_ioctl_wait <= 1'b0;
            r_wr_ovf     <= 1'b0;
        end else begin
            if (w_push) begin
                r_fifo_addr[r_wr_ptr] <= wr_addr;
                r_fifo_data[r_wr_ptr] <= wr_data;
                r_wr_ptr              <= r_wr_ptr + 2'd1;
            end
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 2'd1;
            r_count      <= w_count_next;
            // follows the new count, so it is visible the cycle after the push
            r_ioctl_wait <= (w_count_next >= 3'd3);
            if (wr_req && w_full)
                r_wr_ovf <= 1'b1;
        end
    end

`ifdef SDRAM_SCHED_TIMEOUT_EN
    logic [7:0] r_to_cnt;
    logic       r_rd_timeout;
`endif

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_req       <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= 25'd0;
            r_din       <= 16'd0;
            r_gnt1      <= 1'b0;
            r_last_rd1  <= 1'b0;
            r_rd0_valid <= 1'b0;
            r_rd1_valid <= 1'b0;
            r_rd0_data  <= 32'd0;
            r_rd1_data  <= 32'd0;
`ifdef SDRAM_SCHED_TIMEOUT_EN
            r_to_cnt     <= 8'd0;
            r_rd_timeout <= 1'b0;
`endif
        end else begin
            r_rd0_valid <= 1'b0;
            r_rd1_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        r_state <= S_WR_ISSUE;
                        r_req   <= 1'b1;
                        r_we    <= 1'b1;
                        r_addr  <= r_fifo_addr[r_rd_ptr];
                        r_din   <= r_fifo_data[r_rd_ptr];
                    end else if (!load_en && (rd0_req || rd1_req)) begin
                        r_state    <= S_RD_ISSUE;
                        r_req      <= 1'b1;
                        r_we       <= 1'b0;
                        r_gnt1     <= w_grant1;
                        r_last_rd1 <= w_grant1;
                        r_addr     <= w_grant1 ? rd1_addr : rd0_addr;
                    end
                end
                S_WR_ISSUE: begin
                    if (sdram.sdram_ack) begin
                        r_state <= S_IDLE;
                        r_req   <= 1'b0;
                        r_we    <= 1'b0;
                    end
                end
                S_RD_ISSUE: begin
                    if (sdram.sdram_ack) begin
                        r_state <= S_RD_WAIT;
                        r_req   <= 1'b0;
`ifdef SDRAM_SCHED_TIMEOUT_EN
                        r_to_cnt <= 8'd0;
`endif
                    end
                end
                S_RD_WAIT: begin
                    if (sdram.sdram_rdy) begin
                        r_state <= S_IDLE;
                        if (r_gnt1) begin
                            r_rd1_data  <= sdram.sdram_dout;
                            r_rd1_valid <= 1'b1;
                        end else begin
                            r_rd0_data  <= sdram.sdram_dout;
                            r_rd0_valid <= 1'b1;
                        end
                    end
`ifdef SDRAM_SCHED_TIMEOUT_EN
                    // count 254 means this edge is the 255th without sdram_rdy
                    else if (r_to_cnt == 8'd254) begin
                        r_state      <= S_IDLE;
                        r_rd_timeout <= 1'b1;
                        if (r_gnt1) begin
                            r_rd1_data  <= 32'd0;
                            r_rd1_valid <= 1'b1;
                        end else begin
                            r_rd0_data  <= 32'd0;
                            r_rd0_valid <= 1'b1;
                        end
                    end else begin
                        r_to_cnt <= r_to_cnt + 8'd1;
                    end
`endif
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign sdram.sdram_req  = r_req;
    assign sdram.sdram_we   = r_we;
    assign sdram.sdram_addr = r_addr;
    assign sdram.sdram_din  = r_din;
    assign ioctl_wait       = r_ioctl_wait;
    assign wr_ovf           = r_wr_ovf;
    assign rd0_data         = r_rd0_data;
    assign rd1_data         = r_rd1_data;
    assign rd0_valid        = r_rd0_valid;
    assign rd1_valid        = r_rd1_valid;
    assign dbg_state        = r_state;
`ifdef SDRAM_SCHED_TIMEOUT_EN
    assign rd_timeout       = r_rd_timeout;
`endif

endmodule

// File: tb/tb_sdram_sched.sv
// tb_sdram_sched -- directed bench for sdram_sched: single write, FIFO fill
// and overflow, round-robin reads, write-before-read priority, optional read
// timeout, and reset during a read.
module tb_sdram_sched;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        load_en, wr_req;
    logic [24:0] wr_addr;
    logic [15:0] wr_data;
    logic        ioctl_wait, wr_ovf;
    logic        rd0_req, rd1_req;
    logic [24:0] rd0_addr, rd1_addr;
    logic [31:0] rd0_data, rd1_data;
    logic        rd0_valid, rd1_valid;
    logic [1:0]  dbg_state;
`ifdef SDRAM_SCHED_TIMEOUT_EN
    logic        rd_timeout;
`endif

    sdram_sched_if bus ();

    sdram_sched dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .load_en    (load_en),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .ioctl_wait (ioctl_wait),
        .wr_ovf     (wr_ovf),
        .rd0_req    (rd0_req),
        .rd1_req    (rd1_req),
        .rd0_addr   (rd0_addr),
        .rd1_addr   (rd1_addr),
        .rd0_data   (rd0_data),
        .rd1_data   (rd1_data),
        .rd0_valid  (rd0_valid),
        .rd1_valid  (rd1_valid),
`ifdef SDRAM_SCHED_TIMEOUT_EN
        .rd_timeout (rd_timeout),
`endif
        .dbg_state  (dbg_state),
        .sdram      (bus.master)
    );

    // clock
    always #5 clk_sys = ~clk_sys;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        logic early;

        reset = 1'b1; load_en = 1'b0; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
        rd0_req = 1'b0; rd1_req = 1'b0; rd0_addr = '0; rd1_addr = '0;
        bus.sdram_ack = 1'b0; bus.sdram_rdy = 1'b0; bus.sdram_dout = '0;
        tick(); tick();

        // reset state
        check("rst_req",  bus.sdram_req, 0);
        check("rst_we",   bus.sdram_we, 0);
        check("rst_addr", bus.sdram_addr, 0);
        check("rst_din",  bus.sdram_din, 0);
        check("rst_wait", ioctl_wait, 0);
        check("rst_ovf",  wr_ovf, 0);
        check("rst_v0",   rd0_valid, 0);
        check("rst_v1",   rd1_valid, 0);
        check("rst_d0",   rd0_data, 0);
        check("rst_d1",   rd1_data, 0);
        check("rst_state", dbg_state, 0);
        reset = 1'b0;

        // single write, ack two cycles after req
        load_en = 1'b1;
        wr_req = 1'b1; wr_addr = 25'h000010; wr_data = 16'hA55A;
        tick();
        wr_req = 1'b0;
        check("w1_req_lat", bus.sdram_req, 0);
        tick();
        check("w1_req",  bus.sdram_req, 1);
        check("w1_we",   bus.sdram_we, 1);
        check("w1_addr", bus.sdram_addr, 32'h10);
        check("w1_din",  bus.sdram_din, 32'hA55A);
        tick();
        check("w1_hold", bus.sdram_req, 1);
        bus.sdram_ack = 1'b1;
        tick();
        bus.sdram_ack = 1'b0;
        check("w1_drop",  bus.sdram_req, 0);
        check("w1_idle",  dbg_state, 0);
        tick(); tick();
        check("w1_empty", bus.sdram_req, 0);

        // five back-to-back writes, no ack: backpressure and overflow
        wr_req = 1'b1; wr_addr = 25'h100; wr_data = 16'h1000;
        tick();
        check("f_wait1", ioctl_wait, 0);
        wr_addr = 25'h101; wr_data = 16'h1001;
        tick();
        check("f_wait2", ioctl_wait, 0);
        wr_addr = 25'h102; wr_data = 16'h1002;
        tick();
        check("f_wait3", ioctl_wait, 1);
        wr_addr = 25'h103; wr_data = 16'h1003;
        tick();
        check("f_ovf4", wr_ovf, 0);
        wr_addr = 25'h104; wr_data = 16'h1004;
        tick();
        check("f_ovf5", wr_ovf, 1);
        wr_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            for (int t = 0; t < 10 && !bus.sdram_req; t++) tick();
            check("f_req",  bus.sdram_req, 1);
            check("f_we",   bus.sdram_we, 1);
            check("f_addr", bus.sdram_addr, 32'h100 + k);
            check("f_din",  bus.sdram_din, 32'h1000 + k);
            bus.sdram_ack = 1'b1;
            tick();
            bus.sdram_ack = 1'b0;
        end
        tick(); tick(); tick();
        check("f_dropped", bus.sdram_req, 0);
        check("f_wait_end", ioctl_wait, 0);
        check("f_ovf_sticky", wr_ovf, 1);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("ovf_clear", wr_ovf, 0);

        // tied read requests: rd1 first after reset, then rd0
        load_en = 1'b0;
        rd0_addr = 25'h200; rd1_addr = 25'h300;
        rd0_req = 1'b1; rd1_req = 1'b1;
        tick();
        check("rr1_req",  bus.sdram_req, 1);
        check("rr1_we",   bus.sdram_we, 0);
        check("rr1_addr", bus.sdram_addr, 32'h300);
        bus.sdram_ack = 1'b1;
        tick();
        bus.sdram_ack = 1'b0;
        check("rr1_drop",  bus.sdram_req, 0);
        check("rr1_state", dbg_state, 3);
        tick(); tick();
        bus.sdram_rdy = 1'b1; bus.sdram_dout = 32'h11223344;
        tick();
        bus.sdram_rdy = 1'b0;
        check("rr1_v1", rd1_valid, 1);
        check("rr1_v0", rd0_valid, 0);
        check("rr1_d1", rd1_data, 32'h11223344);
        rd1_req = 1'b0;
        tick();
        check("rr1_pulse", rd1_valid, 0);
        check("rr2_req",  bus.sdram_req, 1);
        check("rr2_addr", bus.sdram_addr, 32'h200);
        bus.sdram_ack = 1'b1;
        tick();
        bus.sdram_ack = 1'b0;
        tick(); tick();
        bus.sdram_rdy = 1'b1; bus.sdram_dout = 32'h55667788;
        tick();
        bus.sdram_rdy = 1'b0;
        check("rr2_v0", rd0_valid, 1);
        check("rr2_v1", rd1_valid, 0);
        check("rr2_d0", rd0_data, 32'h55667788);
        check("rr2_d1_keep", rd1_data, 32'h11223344);
        rd0_req = 1'b0;
        tick();
        check("rr2_pulse", rd0_valid, 0);

        // queued write goes before a read raised alongside it
        wr_req = 1'b1; wr_addr = 25'h400; wr_data = 16'hBEEF;
        tick();
        wr_req = 1'b0;
        rd0_req = 1'b1; rd0_addr = 25'h500;
        tick();
        check("pri_we",   bus.sdram_we, 1);
        check("pri_addr", bus.sdram_addr, 32'h400);
        check("pri_din",  bus.sdram_din, 32'hBEEF);
        bus.sdram_ack = 1'b1;
        tick();
        bus.sdram_ack = 1'b0;
        tick();
        check("pri_rd_req",  bus.sdram_req, 1);
        check("pri_rd_we",   bus.sdram_we, 0);
        check("pri_rd_addr", bus.sdram_addr, 32'h500);
        bus.sdram_ack = 1'b1;
        tick();
        bus.sdram_ack = 1'b0;
        bus.sdram_rdy = 1'b1; bus.sdram_dout = 32'hCAFEF00D;
        tick();
        bus.sdram_rdy = 1'b0;
        check("pri_v0", rd0_valid, 1);
        check("pri_d0", rd0_data, 32'hCAFEF00D);
        rd0_req = 1'b0;
        tick();

`ifdef SDRAM_SCHED_TIMEOUT_EN
        // read with no sdram_rdy times out on the 255th wait cycle
        rd0_req = 1'b1;
        tick();
        bus.sdram_ack = 1'b1;
        tick();
        bus.sdram_ack = 1'b0;
        early = 1'b0;
        for (int t = 0; t < 254; t++) begin
            tick();
            if (rd0_valid || rd_timeout) early = 1'b1;
        end
        check("to_early", early, 0);
        tick();
        check("to_v0",   rd0_valid, 1);
        check("to_d0",   rd0_data, 0);
        check("to_flag", rd_timeout, 1);
        rd0_req = 1'b0;
        tick();
        check("to_sticky", rd_timeout, 1);
`endif

        // reset while waiting for read data
        rd0_req = 1'b1; rd0_addr = 25'h600;
        tick();
        bus.sdram_ack = 1'b1;
        tick();
        bus.sdram_ack = 1'b0;
        tick();
        reset = 1'b1; bus.sdram_rdy = 1'b1; bus.sdram_dout = 32'hDEADBEEF;
        tick();
        reset = 1'b0; bus.sdram_rdy = 1'b0; rd0_req = 1'b0;
        check("rr_req",   bus.sdram_req, 0);
        check("rr_we",    bus.sdram_we, 0);
        check("rr_addr",  bus.sdram_addr, 0);
        check("rr_v0",    rd0_valid, 0);
        check("rr_d0",    rd0_data, 0);
        check("rr_state", dbg_state, 0);
        tick();
        check("rr_v0_late", rd0_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
